// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadow/active double buffer swapped at
// frame wrap, BCD decode with leading-zero blanking, anti-ghost gap, pin polarity.

module sevenseg_digit_dec (
    input  logic [3:0] i_bcd,
    input  logic       i_suppress,
    output logic [6:0] o_seg
);
    // Active-high {A..G}; codes 10..15 show a dash.
    always_comb begin
        o_seg = 7'b0000001;
        case (i_bcd)
            4'd0: o_seg = 7'b1111110;
            4'd1: o_seg = 7'b0110000;
            4'd2: o_seg = 7'b1101101;
            4'd3: o_seg = 7'b1111001;
            4'd4: o_seg = 7'b0110011;
            4'd5: o_seg = 7'b1011011;
            4'd6: o_seg = 7'b1011111;
            4'd7: o_seg = 7'b1110000;
            4'd8: o_seg = 7'b1111111;
            4'd9: o_seg = 7'b1111011;
            default: o_seg = 7'b0000001;
        endcase
        if (i_suppress)
            o_seg = 7'b0000000;
    end
endmodule

module sevenseg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1,
    localparam int IDXW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [4*DIGITS-1:0] i_bcd_in,
    input  logic [DIGITS-1:0]   i_dp_in,
    input  logic                i_load,
    input  logic                i_blank,
    output logic [6:0]          o_seg,
    output logic                o_dp,
    output logic [DIGITS-1:0]   o_an,
    output logic [IDXW-1:0]     o_digit_idx,
    output logic                o_frame_done
);
    localparam int PSW = $clog2(REFRESH_DIV);
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PSW-1:0]               r_presc;
    logic [IDXW-1:0]              r_digit_idx;
    logic                         r_frame_done;
    logic [DIGITS-1:0][3:0]       r_shadow_bcd;
    logic [DIGITS-1:0]            r_shadow_dp;
    logic [DIGITS-1:0][3:0]       r_act_bcd;
    logic [DIGITS-1:0]            r_act_dp;
    logic                         r_pending;
    logic [6:0]                   r_seg;
    logic                         r_dp;
    logic [DIGITS-1:0]            r_an;

    logic                         w_tc;
    logic                         w_wrap;
    logic [DIGITS-1:0]            w_supp;
    logic [DIGITS-1:0][6:0]       w_dig_seg;
    logic [6:0]                   w_seg_sel;
    logic                         w_dp_sel;
    logic [DIGITS-1:0]            w_an_onehot;

    assign w_tc   = (r_presc == PSW'(REFRESH_DIV - 1));
    assign w_wrap = w_tc && (r_digit_idx == IDXW'(DIGITS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc      <= '0;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_act_bcd    <= '0;
            r_act_dp     <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tc) begin
                r_presc     <= '0;
                r_digit_idx <= (r_digit_idx == IDXW'(DIGITS - 1)) ? '0 : r_digit_idx + IDXW'(1);
            end else begin
                r_presc <= r_presc + PSW'(1);
            end
            // A load landing on the wrap edge lands in shadow and waits for the next wrap.
            if (w_wrap && r_pending) begin
                r_act_bcd <= r_shadow_bcd;
                r_act_dp  <= r_shadow_dp;
            end
            if (i_load) begin
                r_shadow_bcd <= i_bcd_in;
                r_shadow_dp  <= i_dp_in;
                r_pending    <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Digit i is blanked when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        logic v_run;
        v_run  = 1'b1;
        w_supp = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_run     = v_run && (r_act_bcd[i] == 4'd0);
            w_supp[i] = (LZ_BLANK != 0) && v_run && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        sevenseg_digit_dec u_dec (
            .i_bcd      (r_act_bcd[g]),
            .i_suppress (w_supp[g]),
            .o_seg      (w_dig_seg[g])
        );
    end

    always_comb begin
        w_an_onehot = '0;
        for (int i = 0; i < DIGITS; i++)
            w_an_onehot[i] = (r_digit_idx == IDXW'(i));
    end

    assign w_seg_sel = w_dig_seg[r_digit_idx];
    assign w_dp_sel  = r_act_dp[r_digit_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_sel : w_seg_sel;
            r_dp  <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_sel : w_dp_sel;
            // Dark on the slot's last cycle so the digit switch never ghosts.
            if (i_blank || w_tc)
                r_an <= AN_OFF;
            else
                r_an <= (AN_ACTIVE_LOW != 0) ? ~w_an_onehot : w_an_onehot;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_an         = r_an;
    assign o_digit_idx  = r_digit_idx;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: cycle-arithmetic display model checked every cycle,
// plus literal segment/anode expectations for the directed scenarios.

module tb_sevenseg_scan_driver;
    localparam int DG = 4;
    localparam int RD = 4;
    localparam int FR = DG * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_err = 0;

    sevenseg_scan_driver #(
        .DIGITS(DG), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bcd_in(bcd_in), .i_dp_in(dp_in),
        .i_load(load), .i_blank(blank), .o_seg(seg), .o_dp(dp), .o_an(an),
        .o_digit_idx(digit_idx), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: scan position is pure arithmetic on the cycle count since reset.
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;  4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;  4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;  4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;  4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;  4'd9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic int pos(input int cyc);
        return (cyc / RD) % DG;
    endfunction

    function automatic logic [6:0] f_seg(input logic [15:0] w, input int cyc);
        int i;
        i = pos(cyc);
        if (i != 0 && (w >> (4 * i)) == 16'd0) return 7'h7F;
        return ~dec(w[4*i +: 4]);
    endfunction

    function automatic logic [3:0] f_an(input int cyc, input logic blk);
        logic [3:0] one;
        if (blk || (cyc % RD) == RD - 1) return 4'hF;
        one = 4'b0001 << pos(cyc);
        return ~one;
    endfunction

    int          m_cyc;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_sdp;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0; m_act <= '0; m_sh <= '0; m_adp <= '0; m_sdp <= '0; m_pend <= 1'b0;
            e_seg <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF; e_fd <= 1'b0;
        end else begin
            e_seg <= f_seg(m_act, m_cyc);
            e_dp  <= ~m_adp[pos(m_cyc)];
            e_an  <= f_an(m_cyc, blank);
            e_fd  <= (m_cyc % FR) == FR - 1;
            m_cyc <= m_cyc + 1;
            if ((m_cyc % FR) == FR - 1 && m_pend) begin
                m_act <= m_sh;
                m_adp <= m_sdp;
            end
            if (load) begin
                m_sh <= bcd_in; m_sdp <= dp_in; m_pend <= 1'b1;
            end else if ((m_cyc % FR) == FR - 1) begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_seg", seg, e_seg);
        chk("model_dp", dp, e_dp);
        chk("model_an", an, e_an);
        chk("model_frame_done", frame_done, e_fd);
        chk("model_digit_idx", digit_idx, pos(m_cyc));
    end

    task automatic wait_an(input logic [3:0] t);
        int n = 0;
        do begin @(negedge clk); n++; end while (an !== t && n < 100);
        if (an !== t) chk("wait_an_timeout", an, t);
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) chk("wait_fd_timeout", frame_done, 1);
    endtask

    initial begin
        int n;
        logic [3:0] seen;
        int fds;

        // Reset and idle scan of an all-zero buffer
        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_an0", an, 4'b1110);
        chk("t1_seg0", seg, 7'b0000001);
        wait_an(4'b1101);
        chk("t1_seg1_supp", seg, 7'h7F);
        wait_fd(n);
        wait_fd(n);
        chk("t1_fd_period", n, 16);

        // Load mid-frame: held off until the wrap
        repeat (5) @(negedge clk);
        bcd_in = 16'h1208; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_an(4'b1011);
        chk("t2_unchanged", seg, 7'h7F);
        wait_fd(n);
        wait_an(4'b1110); chk("t2_d0_8", seg, 7'b0000000);
        wait_an(4'b1101); chk("t2_d1_0", seg, 7'b0000001);
        wait_an(4'b1011); chk("t2_d2_2", seg, 7'b0010010);
        wait_an(4'b0111); chk("t2_d3_1", seg, 7'b1001111);

        // Invalid code counts as nonzero, shows a dash
        repeat (2) @(negedge clk);
        bcd_in = 16'h00A5; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_fd(n);
        wait_an(4'b1110); chk("t3_d0_5", seg, 7'b0100100);
        wait_an(4'b1101); chk("t3_d1_dash", seg, 7'b1111110);
        wait_an(4'b1011); chk("t3_d2_supp", seg, 7'h7F);
        wait_an(4'b0111); chk("t3_d3_supp", seg, 7'h7F);

        // Load on the wrap cycle while 9999 is pending
        wait_fd(n);
        repeat (2) @(negedge clk);
        bcd_in = 16'h9999; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (12) @(negedge clk);
        bcd_in = 16'h4321; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("t4_fd_on_wrap", frame_done, 1);
        wait_an(4'b1110); chk("t4_d0_9", seg, 7'b0000100);
        wait_an(4'b0111); chk("t4_d3_9", seg, 7'b0000100);
        wait_fd(n);
        wait_an(4'b1110); chk("t4_d0_1", seg, 7'b1001111);
        wait_an(4'b0111); chk("t4_d3_4", seg, 7'b1001100);

        // Global blank keeps scanning
        blank = 1'b1;
        seen = '0; fds = 0;
        @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            chk("t5_blank_an", an, 4'hF);
            seen[digit_idx] = 1'b1;
            if (frame_done) fds++;
        end
        chk("t5_idx_advance", seen, 4'hF);
        chk("t5_fd_pulsed", fds >= 1, 1);
        blank = 1'b0;
        dp_in = 4'b0100; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_fd(n);
        wait_fd(n);
        repeat (16) begin
            @(negedge clk);
            if (an == 4'b1011) chk("t5_dp_on", dp, 1'b0);
            else if (an != 4'hF) chk("t5_dp_off", dp, 1'b1);
        end

        // Asynchronous reset mid-slot
        wait_an(4'b1110);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_seg", seg, 7'h7F);
        chk("t6_dp", dp, 1'b1);
        chk("t6_an", an, 4'hF);
        chk("t6_idx", digit_idx, 0);
        chk("t6_fd", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_idx_after", digit_idx, 0);
        chk("t6_an_after", an, 4'b1110);
        chk("t6_seg_after", seg, 7'b0000001);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Parametrised, time-multiplexed driver for a DIGITS-wide common-anode or common-cathode 7-segment display. It captures a packed BCD word and decimal points into a shadow buffer. The buffer is applied only at frame boundaries, so the display never tears. The block scans one digit per refresh slot and decodes BCD to segments. It adds leading-zero suppression, a dash pattern for invalid codes, a global blank, and anti-ghosting. It sits between datapath counters/registers and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned; legal 1..8
REFRESH_DIV, 100000, clk cycles per digit slot; legal >= 2
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low, 0 = active-high
AN_ACTIVE_LOW, 1, 1 = anode pins active-low, 0 = active-high
LZ_BLANK, 1, 1 = leading-zero suppression enabled

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bcd_in  in  4*DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant (rightmost)
dp_in  in  DIGITS  decimal point per digit, 1 = lit
load  in  1  one-cycle strobe; captures bcd_in/dp_in into shadow
blank  in  1  1 = all anodes inactive; scanning continues
seg  out  7  {A,B,C,D,E,F,G}, seg[6] = A; registered
dp  out  1  decimal point; registered
an  out  DIGITS  anode enables, an[i] selects digit i; registered
digit_idx  out  max(1,$clog2(DIGITS))  index of digit currently scanned
frame_done  out  1  one-cycle pulse when scan wraps DIGITS-1 -> 0

Behaviour:
- Reset (async assert, sync release):
  - prescaler, digit_idx, shadow, active buffer and pending flag all 0; frame_done 0.
  - seg and dp at inactive level; all an inactive.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit_idx advances by 1; DIGITS-1 wraps to 0.
  - On the wrap to 0, frame_done = 1 for that same single cycle.
  - DIGITS = 1: digit_idx stays 0; frame_done pulses every REFRESH_DIV cycles.
- Buffering:
  - load=1 copies bcd_in/dp_in into shadow and sets pending; the latest load wins.
  - At frame wrap with pending=1: active <= shadow and pending clears.
  - load coincident with wrap: the old shadow is applied; the new data lands in shadow, pending stays 1, and it is applied at the next wrap.
- Decode (active-high form, before polarity):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - 10..15 -> dash 0000001.
- Leading-zero suppression (LZ_BLANK=1):
  - Digit i is suppressed if it and every digit above it hold 0.
  - Digit 0 is never suppressed.
  - An invalid code counts as nonzero.
  - A suppressed digit drives seg all-inactive; its dp is still driven from the buffer.
- Anode:
  - an[digit_idx] is active; all others inactive.
  - All an are inactive while blank=1.
  - All an are also inactive during the cycle in which the prescaler equals REFRESH_DIV-1 (anti-ghost gap).
- Polarity:
  - Final seg/dp are inverted if SEG_ACTIVE_LOW.
  - Final an is inverted if AN_ACTIVE_LOW.
- Latency:
  - seg/dp/an are registered, one cycle behind the digit_idx/prescaler state that selects them.
  - Visible effect of a load: no later than the end of the next full frame after capture.
- Reset mid-scan returns everything to reset values immediately, with no glitch on an beyond the inactive level.

Test Plan:
1. Reset release, DIGITS=4, REFRESH_DIV=4, active-low, no load -> an cycles 1110,1101,1011,0111 per 4-cycle slot with a 1111 gap cycle each slot; digit 0 seg=0000001 ("0"); digits 1-3 seg=1111111 (suppressed); frame_done every 16 cycles.
2. load bcd_in=16'h1208 mid-frame -> display unchanged until the next frame_done, then digits 3..0 show 1,2,0,8; digit 1 "0" not suppressed (a nonzero digit lies above it).
3. bcd_in=16'h00A5 -> digit 1 dash (active-low seg=1111110), digit 0 "5"; digits 3,2 blank.
4. load asserted in the same cycle as frame_done with 16'h4321, pending old 16'h9999 -> 9999 shown this frame, 4321 the following frame.
5. blank=1 for 20 cycles -> an=1111 throughout, digit_idx keeps advancing, frame_done still pulses; dp_in=4'b0100 with blank=0 -> dp low only while an[2] is active.
6. Assert rst_n=0 asynchronously mid-slot -> seg=1111111, dp=1, an=1111 without waiting for a clk edge; digit_idx=0 after release.
